// File: rtl/answer_printer_pkg.sv
// Shared types and constants for the answer printer.
//   state_t      : controller state encoding
//   ASCII_ZERO   : '0' character, added to a BCD digit to form its glyph
//   ASCII_LF     : line-feed terminator (used only with ANSWER_PRINTER_NEWLINE_EN)
//   min_digits() : decimal digits needed to hold any WIDTH-bit unsigned value
package answer_printer_pkg;

  typedef enum logic [2:0] {IDLE, CONV, SKIP, EMIT, TERM, FIN} state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // ceil(width * log10(2)) in integer arithmetic (log10(2) ~= 0.30103).
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/answer_printer_bcd_dabble_step.sv
// One double-dabble iteration, purely combinational.
//   bcd      : current BCD accumulator, DIGITS nibbles
//   bit_in   : next binary bit (MSB of the shift register)
//   bcd_next : every nibble >= 5 bumped by 3, then shifted left with bit_in
module bcd_dabble_step #(
  parameter int DIGITS = 10
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] bcd_next
);

  // The top nibble's MSB falls off the shift; the DIGITS sizing rule keeps it
  // zero, so only three bits of that nibble are carried.
  logic [4*DIGITS-2:0] adj;

  for (genvar d = 0; d < DIGITS; d++) begin : g_nib
    logic [3:0] nib;
    assign nib = bcd[4*d +: 4];
    if (d == DIGITS-1) begin : g_top
      assign adj[4*d +: 3] = (nib >= 4'd5) ? nib[2:0] + 3'd3 : nib[2:0];
    end else begin : g_mid
      assign adj[4*d +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  assign bcd_next = {adj, bit_in};

endmodule

// File: rtl/answer_printer.sv
// Prints a solver's binary answer as decimal ASCII over a byte handshake.
// On a rising edge of done (while idle) the result is captured, converted by
// double-dabble (WIDTH cycles), leading zeros are skipped, and the digits are
// streamed MSB first.
// Optional: define ANSWER_PRINTER_NEWLINE_EN to append an LF after the digits.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   done,result : solver finish level and answer
//   out_data, out_valid, out_ready : byte stream to the sink
//   busy        : capture through acceptance of the last byte
//   printed     : sticky, set after a complete print
module answer_printer
  import answer_printer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  input  logic [WIDTH-1:0] result,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             printed
);

  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
    $error("answer_printer: DIGITS is too small to hold a WIDTH-bit result");
  end

  state_t              state;
  logic                done_q;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] bcd_next;
  logic [WIDTH-1:0]    shreg;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_dn;
  logic [3:0]          dig_cur;
  logic [3:0]          dig_dn;

  assign ptr_dn  = ptr - 1'b1;
  assign dig_cur = bcd[4*int'(ptr) +: 4];
  // Digit for the following EMIT cycle, so back-to-back bytes need no bubble.
  assign dig_dn  = bcd[4*int'(ptr_dn) +: 4];

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .bcd      (bcd),
    .bit_in   (shreg[WIDTH-1]),
    .bcd_next (bcd_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      bcd       <= '0;
      shreg     <= '0;
      cnt       <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
      printed   <= 1'b0;
    end else begin
      done_q <= done;
      case (state)
        IDLE: begin
          if (done && !done_q) begin
            shreg <= result;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd   <= bcd_next;
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            ptr   <= PW'(DIGITS-1);
            state <= SKIP;
          end
        end
        SKIP: begin
          // Digit 0 is never skipped so a zero result still prints "0".
          if (dig_cur == 4'd0 && ptr != '0) begin
            ptr <= ptr_dn;
          end else begin
            out_valid <= 1'b1;
            out_data  <= ASCII_ZERO + {4'h0, dig_cur};
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (ptr != '0) begin
              ptr      <= ptr_dn;
              out_data <= ASCII_ZERO + {4'h0, dig_dn};
            end else begin
`ifdef ANSWER_PRINTER_NEWLINE_EN
              out_data <= ASCII_LF;
              state    <= TERM;
`else
              out_valid <= 1'b0;
              out_data  <= 8'h00;
              busy      <= 1'b0;
              printed   <= 1'b1;
              state     <= FIN;
`endif
            end
          end
        end
`ifdef ANSWER_PRINTER_NEWLINE_EN
        TERM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            busy      <= 1'b0;
            printed   <= 1'b1;
            state     <= FIN;
          end
        end
`endif
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_answer_printer.sv
// Bench for answer_printer: a decimal-string model feeds an expected-byte
// queue that a per-cycle monitor drains, plus directed literal checks on
// latency, status flags, reset abort and re-trigger behaviour.
module tb_answer_printer;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             printed;

  int compared   = 0;
  int mismatched = 0;
  int ready_mode = 0;   // 0: always ready, 1: ready one cycle in three, 2: never

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  answer_printer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .result    (result),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .printed   (printed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Model: decimal text of v, MSB first, no leading zeros.
  task automatic push_expected(input logic [WIDTH-1:0] v);
    logic [7:0]       d[$];
    logic [WIDTH-1:0] t;
    t = v;
    if (t == '0) d.push_front(8'h30);
    while (t != '0) begin
      d.push_front(8'h30 + 8'(t % 10));
      t = t / 10;
    end
    foreach (d[i]) exp_q.push_back(d[i]);
`ifdef ANSWER_PRINTER_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Sink ready pattern, changed just after each rising edge.
  initial begin
    int rc;
    rc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rc % 3 == 0);
        default: out_ready = 1'b0;
      endcase
      rc++;
    end
  end

  // Compare process: every accepted byte against the model, stability while
  // stalled, and quiet data when not valid.
  initial begin
    bit         hold_prev;
    logic [7:0] data_prev;
    hold_prev = 1'b0;
    data_prev = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(out_data), int'(data_prev));
        end
        if (!out_valid) check("idle_data", int'(out_data), 0);
        if (out_valid && out_ready) begin
          rx_q.push_back(out_data);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_data);
          end else begin
            check("byte", int'(out_data), int'(exp_q.pop_front()));
          end
        end
        hold_prev = out_valid && !out_ready;
        data_prev = out_data;
      end
    end
  end

  // Received bytes against a hand-written literal string.
  task automatic check_rx(input string name, input string s);
    logic [7:0] e[$];
    string      rs;
    bit         ok;
    for (int i = 0; i < s.len(); i++) e.push_back(s[i]);
`ifdef ANSWER_PRINTER_NEWLINE_EN
    e.push_back(8'h0A);
`endif
    ok = (e.size() == rx_q.size());
    if (ok) foreach (e[i]) if (e[i] != rx_q[i]) ok = 1'b0;
    rs = "";
    foreach (rx_q[i]) rs = {rs, $sformatf("%02h ", rx_q[i])};
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s_text: got bytes [%s], expected \"%s\"", name, rs, s);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 500);
    check({name, "_finish"}, int'(busy), 0);
  endtask

  task automatic do_print(input string name, input logic [WIDTH-1:0] v,
                          input int z, input string s);
    int n;
    bit seen;
    rx_q.delete();
    @(posedge clk);
    #1;
    result = v;
    done   = 1'b1;
    push_expected(v);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check({name, "_busy_at_capture"}, int'(busy), 1);
      if (out_valid) seen = 1'b1;
    end
    check({name, "_first_valid_edges"}, n, WIDTH + 2 + z);
    wait_idle(name);
    check({name, "_printed"}, int'(printed), 1);
    check({name, "_valid_after"}, int'(out_valid), 0);
    check({name, "_model_drained"}, exp_q.size(), 0);
    check_rx(name, s);
  endtask

  task automatic lower_done();
    @(posedge clk);
    #1;
    done = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nbytes;
    reset  = 1'b1;
    done   = 1'b0;
    result = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_printed", int'(printed), 0);

`ifdef ANSWER_PRINTER_NEWLINE_EN
    nbytes = 7;
`else
    nbytes = 6;
`endif

    // Main case, then done held high for 200 cycles: no re-trigger.
    do_print("p233168", 32'd233168, 4, "233168");
    repeat (200) @(negedge clk);
    check("held_done_bytes", rx_q.size(), nbytes);
    check("held_done_busy", int'(busy), 0);
    lower_done();

    // A fresh rising edge prints again.
    do_print("second", 32'd233168, 4, "233168");
    lower_done();

    do_print("zero", 32'd0, 9, "0");
    lower_done();

    do_print("allones", 32'hFFFF_FFFF, 0, "4294967295");
    lower_done();

    ready_mode = 1;
    do_print("slow_sink", 32'd233168, 4, "233168");
    ready_mode = 0;
    lower_done();

    // Reset right after the third byte is accepted.
    rx_q.delete();
    @(posedge clk);
    #1;
    result = 32'd233168;
    done   = 1'b1;
    push_expected(32'd233168);
    k = 0;
    while (rx_q.size() < 3 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("abort_three_bytes", rx_q.size(), 3);
    #2;
    ready_mode = 2;
    out_ready  = 1'b0;
    reset      = 1'b1;
    done       = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_printed", int'(printed), 0);
    check("abort_data", int'(out_data), 0);
    ready_mode = 0;
    repeat (60) @(negedge clk);
    check("abort_no_more_bytes", rx_q.size(), 3);
    check("abort_still_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
